// File: rtl/div_seq_32.sv
// -----------------------------------------------------------------------------
// div_seq_32 : iterative signed integer divider (restoring, one quotient bit
//              per clock) for the mult-div unit.
//
// A start pulse on ctrl_DIV samples both operands. The divider then runs
// WIDTH restoring steps and presents the quotient, truncated toward zero,
// together with an exception flag. A one-cycle data_resultRDY pulse marks the
// result. A new start in any state abandons the operation in flight. No ready
// pulse is issued for an abandoned operation.
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-high reset (priority over ctrl_DIV)
//   ctrl_DIV        start pulse; operands are sampled on the same edge
//   data_operandA   dividend, two's complement, WIDTH bits
//   data_operandB   divisor,  two's complement, WIDTH bits
//   data_result     quotient, held from the DONE entry until the next one
//   data_exception  divide-by-zero or overflow (-2^(W-1) / -1)
//   data_resultRDY  high for exactly the one cycle spent in DONE
//   busy            high while iterating (state RUN)
// -----------------------------------------------------------------------------
module div_seq_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Count value of the step that retires the final quotient bit.
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    // Most negative dividend and the all-ones divisor form the single
    // overflowing pair.
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MINUS_1  = {WIDTH{1'b1}};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]       state_reg,     state_next;
    logic [CW-1:0]    count_reg,     count_next;
    logic [WIDTH-1:0] rem_reg,       rem_next;      // upper half of {rem,quo}
    logic [WIDTH-1:0] quo_reg,       quo_next;      // lower half of {rem,quo}
    logic [WIDTH-1:0] divisor_reg,   divisor_next;  // |B|
    logic             sign_reg,      sign_next;     // quotient sign
    logic             div_zero_reg,  div_zero_next;
    logic             overflow_reg,  overflow_next;
    logic [WIDTH-1:0] result_reg,    result_next;
    logic             exception_reg, exception_next;

    // -------------------------------------------------------------------------
    // Operand conditioning
    // -------------------------------------------------------------------------
    // Magnitudes are treated as unsigned WIDTH-bit numbers. This form also
    // handles the most negative value, whose magnitude 2^(W-1) still fits.
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign abs_a = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    assign abs_b = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

    // -------------------------------------------------------------------------
    // One restoring step on the combined {rem,quo} register
    // -------------------------------------------------------------------------
    // After the left shift, the partial remainder is the old remainder with
    // the next dividend bit appended. The remainder always stays below |B|,
    // which is at most 2^(W-1). The partial remainder therefore fits in WIDTH
    // bits. The compare is still done at WIDTH+1 bits so the borrow never
    // aliases.
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    assign partial  = {rem_reg, quo_reg[WIDTH-1]};
    assign trial    = partial - {1'b0, divisor_reg};
    assign fits     = (partial >= {1'b0, divisor_reg});
    assign rem_step = fits ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
    assign quo_step = {quo_reg[WIDTH-2:0], fits};

    // -------------------------------------------------------------------------
    // Final result formation, used only on the step that enters DONE
    // -------------------------------------------------------------------------
    // Divide-by-zero takes precedence over overflow. The two flags can never
    // both be set, because the overflow divisor is nonzero.
    logic [WIDTH-1:0] quo_signed;
    logic [WIDTH-1:0] final_result;
    logic             final_exception;

    assign quo_signed = sign_reg ? (~quo_step + 1'b1) : quo_step;

    always_comb begin
        final_result    = quo_signed;
        final_exception = 1'b0;
        if (div_zero_reg) begin
            final_result    = '0;
            final_exception = 1'b1;
        end else if (overflow_reg) begin
            final_result    = MOST_NEG;
            final_exception = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        rem_next       = rem_reg;
        quo_next       = quo_reg;
        divisor_next   = divisor_reg;
        sign_next      = sign_reg;
        div_zero_next  = div_zero_reg;
        overflow_next  = overflow_reg;
        result_next    = result_reg;
        exception_next = exception_reg;

        if (ctrl_DIV) begin
            // A start in any state loads a fresh operation. Any operation in
            // flight is dropped without a ready pulse.
            state_next    = RUN;
            count_next    = '0;
            rem_next      = '0;
            quo_next      = abs_a;
            divisor_next  = abs_b;
            sign_next     = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero_next = (data_operandB == '0);
            overflow_next = (data_operandA == MOST_NEG) && (data_operandB == MINUS_1);
        end else begin
            case (state_reg)
                RUN: begin
                    rem_next   = rem_step;
                    quo_next   = quo_step;
                    // The counter wraps from LAST_STEP back to zero.
                    count_next = count_reg + CW'(1);
                    if (count_reg == LAST_STEP) begin
                        state_next     = DONE;
                        result_next    = final_result;
                        exception_next = final_exception;
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                IDLE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            divisor_reg   <= '0;
            sign_reg      <= 1'b0;
            div_zero_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            result_reg    <= '0;
            exception_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            rem_reg       <= rem_next;
            quo_reg       <= quo_next;
            divisor_reg   <= divisor_next;
            sign_reg      <= sign_next;
            div_zero_reg  <= div_zero_next;
            overflow_reg  <= overflow_next;
            result_reg    <= result_next;
            exception_reg <= exception_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign data_result    = result_reg;
    assign data_exception = exception_reg;
    assign data_resultRDY = (state_reg == DONE);
    assign busy           = (state_reg == RUN);

endmodule

// File: tb/tb_div_seq_32.sv
// -----------------------------------------------------------------------------
// tb_div_seq_32 : scoreboard bench for div_seq_32.
// The stimulus pushes the expected result, exception flag and ready cycle of
// every operation that should complete. A separate monitor pops one entry and
// compares it on each ready pulse.
// -----------------------------------------------------------------------------
module tb_div_seq_32;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    div_seq_32 #(.WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          cyc;
        int          id;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int busy_cnt = 0;
    int next_id  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset && busy) busy_cnt++;
        if (!reset && data_resultRDY) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ready: result=%h exc=%b at cycle %0d, no op pending",
                         data_result, data_exception, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("op %0d: %h / %h -> result=%h exc=%b cycle=%0d",
                         e.id, e.a, e.b, data_result, data_exception, cyc);
                check("result", data_result, e.res);
                check("exception", {31'd0, data_exception}, {31'd0, e.exc});
                check("ready_cycle", cyc, e.cyc);
            end
        end
    end

    // Drives one start pulse. The caller must be at a falling edge. The task
    // returns at the next falling edge with ctrl_DIV released.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic exc, input bit push);
        exp_t e;
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        if (push) begin
            e.res = res;
            e.exc = exc;
            e.cyc = cyc + 33;   // sampled at the coming edge, ready 32 edges later
            e.id  = next_id;
            e.a   = a;
            e.b   = b;
            next_id++;
            sb.push_back(e);
        end
        @(negedge clk);
        ctrl_DIV = 1'b0;
    endtask

    task automatic drain;
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d ops still pending, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic e);
        int ia, ib;
        ia = a;
        ib = b;
        if (b == 32'd0) begin
            q = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            e = 1'b1;
        end else begin
            q = ia / ib;
            e = 1'b0;
        end
    endfunction

    // Directed vectors: dividend, divisor, hand-computed quotient and exception.
    logic [31:0] vec_a   [12] = '{32'd7, 32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C, 32'd7,
                                  32'h7FFF_FFFF, 32'd5, 32'h8000_0000, 32'd9,
                                  32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] vec_b   [12] = '{32'd100, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100,
                                  32'd1, 32'd0, 32'hFFFF_FFFF, 32'd3,
                                  32'd1, 32'd2, 32'd2};
    logic [31:0] vec_q   [12] = '{32'd0, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd14, 32'd0,
                                  32'h7FFF_FFFF, 32'd0, 32'h8000_0000, 32'd3,
                                  32'h8000_0000, 32'hC000_0000, 32'hFFFF_FFFD};
    logic        vec_e   [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b1, 1'b1, 1'b0,
                                  1'b0, 1'b0, 1'b0};

    initial begin
        logic [31:0] ra, rb, rq;
        logic        re;

        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state.
        check("reset_busy",   {31'd0, busy}, 32'd0);
        check("reset_ready",  {31'd0, data_resultRDY}, 32'd0);
        check("reset_result", data_result, 32'd0);
        check("reset_exc",    {31'd0, data_exception}, 32'd0);

        // Basic 100/7, including the number of busy cycles.
        busy_cnt = 0;
        issue(32'd100, 32'd7, 32'd14, 1'b0, 1'b1);
        drain();
        check("busy_cycles", busy_cnt, 32);

        // Reset mid-run: the op in flight is dropped and the outputs are cleared.
        issue(32'd100, 32'd7, 32'd0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("midrst_busy",   {31'd0, busy}, 32'd0);
        check("midrst_ready",  {31'd0, data_resultRDY}, 32'd0);
        check("midrst_result", data_result, 32'd0);
        repeat (40) @(negedge clk);

        // Directed sign, boundary and exception cases.
        for (int i = 0; i < 12; i++) begin
            issue(vec_a[i], vec_b[i], vec_q[i], vec_e[i], 1'b1);
            drain();
        end

        // Restart at E10: only the second op completes, at E42.
        issue(32'd100, 32'd7, 32'd0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        issue(32'd50, 32'd5, 32'd10, 1'b0, 1'b1);
        drain();

        // Back-to-back: the second start lands in the DONE cycle of the first.
        issue(32'd1000, 32'd10, 32'd100, 1'b0, 1'b1);
        repeat (32) @(negedge clk);
        issue(32'hFFFF_FC18, 32'd3, 32'hFFFF_FEB3, 1'b0, 1'b1);   // -1000/3 = -333
        drain();

        // Random operand pairs against the reference model.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            case (i % 4)
                0: rb = $urandom;
                1: rb = $urandom_range(0, 15);
                2: rb = 32'd0 - $urandom_range(1, 300);
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            ref_div(ra, rb, rq, re);
            issue(ra, rb, rq, re, 1'b1);
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
